mem_stage_ctrl: RTL and testbench

Multi-cycle data-memory stage that sits after the decode stage. It consumes the store operand produced by decode (RF_B, or its zero-extended low byte for sb) and produces the MEM_out word that decode writes back. Word accesses go straight to memory. Byte stores run a read-modify-write sequence. Byte loads return the addressed lane right-justified in bits [7:0], which is the position decode's lb path extracts. A Start/Done handshake connects the block to the datapath control FSM.

---
 rtl/mem_stage_ctrl_pkg.sv | 36 +++
 rtl/dmem_sp_ram.sv | 23 ++
 rtl/mem_stage_ctrl.sv | 113 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared types and byte-lane helpers for the data-memory stage
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_0400;

  // Little-endian: lane 0 is bits [7:0].
  function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] data);
    logic [31:0] merged;
    merged = word;
    case (lane)
      2'd0:    merged[7:0]   = data;
      2'd1:    merged[15:8]  = data;
      2'd2:    merged[23:16] = data;
      default: merged[31:24] = data;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// rtl/dmem_sp_ram.sv - DEPTH x 32 single-port RAM with synchronous 1-cycle read
module dmem_sp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) mem[addr] <= wdata;
      else       rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - multi-cycle data-memory stage: word access, byte load, byte-store RMW
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int          AW        = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_DataIn,
  input  logic        MEM_WrEn,
  input  logic        Byte_op,
  output logic [31:0] MEM_DataOut,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, data_q, dout_q;
  logic        wren_q, byte_q, err_q;

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        bad;

  logic        ram_en, ram_we;
  logic [31:0] ram_wdata, ram_rdata;

  // Addresses below BASE_ADDR wrap to large offsets and fail the range test.
  assign off  = addr_q - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign lane = off[1:0];
  assign bad  = (off >= SPAN) || (!byte_q && lane != 2'd0);

  dmem_sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (Clk),
    .en    (ram_en),
    .wr_en (ram_we),
    .addr  (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = data_q;
    case (state_q)
      IDLE: if (Start) state_d = ACCESS;
      ACCESS: begin
        if (bad) begin
          state_d = DONE;
        end else if (wren_q && !byte_q) begin
          ram_en  = 1'b1;
          ram_we  = 1'b1;
          state_d = DONE;
        end else begin
          ram_en  = 1'b1;
          state_d = MERGE;
        end
      end
      MERGE: begin
        if (wren_q) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = byte_merge(ram_rdata, lane, data_q[7:0]);
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      byte_q  <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (Start) begin
          addr_q <= MEM_Addr;
          data_q <= MEM_DataIn;
          wren_q <= MEM_WrEn;
          byte_q <= Byte_op;
          err_q  <= 1'b0;
        end
        ACCESS: if (bad) err_q <= 1'b1;
        MERGE: if (!wren_q) dout_q <= byte_q ? {24'b0, lane_select(ram_rdata, lane)} : ram_rdata;
        default: ;
      endcase
    end
  end

  assign MEM_DataOut = dout_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = (state_q == DONE);
  assign Err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - vector table, corner sequences and randomized model check for mem_stage_ctrl
module tb_mem_stage_ctrl;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] MEM_Addr = '0;
  logic [31:0] MEM_DataIn = '0;
  logic        MEM_WrEn = 1'b0;
  logic        Byte_op = 1'b0;
  logic [31:0] MEM_DataOut;
  logic        Busy, Done, Err;

  int checks = 0;
  int failures = 0;

  mem_stage_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .AW(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MEM_Addr(MEM_Addr),
    .MEM_DataIn(MEM_DataIn), .MEM_WrEn(MEM_WrEn), .Byte_op(Byte_op),
    .MEM_DataOut(MEM_DataOut), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        bop;
    int          lat;
    logic        err;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: word array plus last load result
  bit [31:0] m_mem [DEPTH];
  bit [31:0] m_dout;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] a, input logic [31:0] d, input logic wr,
                     input logic bop, input int lat, input logic e, input logic [31:0] q);
    vec_t v;
    v.name = n; v.addr = a; v.data = d; v.wr = wr; v.bop = bop; v.lat = lat; v.err = e; v.dout = q;
    vecs.push_back(v);
  endtask

  // Latency counts the capture edge as 1; lat=99 flags a timeout.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic bop,
                        output int lat, output logic e, output logic [31:0] q);
    @(negedge Clk);
    MEM_Addr = a; MEM_DataIn = d; MEM_WrEn = wr; Byte_op = bop; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = 1;
    while (!Done && lat < 10) begin
      @(posedge Clk);
      #1 lat++;
    end
    if (!Done) lat = 99;
    e = Err;
    q = MEM_DataOut;
    @(posedge Clk);
    #1;
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic wr,
                                input logic bop, output int lat, output logic e);
    longint ua, lo, widx, ln;
    bit [31:0] mask;
    ua = longint'(a);
    lo = longint'(BASE);
    e = (ua < lo) || (ua >= lo + 4 * DEPTH) || (!bop && (ua % 4) != 0);
    if (e) begin
      lat = 2;
      return;
    end
    widx = (ua - lo) / 4;
    ln   = (ua - lo) % 4;
    mask = 32'hFF << (8 * ln);
    if (wr && !bop) begin
      lat = 2;
      m_mem[widx] = d;
    end else begin
      lat = 3;
      if (wr) m_mem[widx] = (m_mem[widx] & ~mask) | ((d & 32'hFF) << (8 * ln));
      else if (bop) m_dout = (m_mem[widx] & mask) >> (8 * ln);
      else m_dout = m_mem[widx];
    end
  endfunction

  initial begin
    int lat, exp_lat, dones;
    logic e, exp_e;
    logic [31:0] q, a, d;
    logic wr, bop;

    add("sw_404",     32'h404,  32'hDEADBEEF, 1, 0, 2, 0, 32'h0);
    add("lw_404",     32'h404,  32'h0,        0, 0, 3, 0, 32'hDEADBEEF);
    add("sb_406",     32'h406,  32'h000000AA, 1, 1, 3, 0, 32'hDEADBEEF);
    add("lw_404_rmw", 32'h404,  32'h0,        0, 0, 3, 0, 32'hDEAABEEF);
    add("lb_404",     32'h404,  32'h0,        0, 1, 3, 0, 32'h000000EF);
    add("lb_405",     32'h405,  32'h0,        0, 1, 3, 0, 32'h000000BE);
    add("lb_406",     32'h406,  32'h0,        0, 1, 3, 0, 32'h000000AA);
    add("lb_407",     32'h407,  32'h0,        0, 1, 3, 0, 32'h000000DE);
    add("lw_402_mis", 32'h402,  32'h0,        0, 0, 2, 1, 32'h000000DE);
    add("sw_1400_oor",32'h1400, 32'h12345678, 1, 0, 2, 1, 32'h000000DE);
    add("lw_3fc_low", 32'h3FC,  32'h0,        0, 0, 2, 1, 32'h000000DE);
    add("lw_404_keep",32'h404,  32'h0,        0, 0, 3, 0, 32'hDEAABEEF);
    add("sw_13fc_top",32'h13FC, 32'h12345678, 1, 0, 2, 0, 32'hDEAABEEF);
    add("lw_13fc_top",32'h13FC, 32'h0,        0, 0, 3, 0, 32'h12345678);
    add("sb_404_hi",  32'h404,  32'hFFFFFF11, 1, 1, 3, 0, 32'h12345678);
    add("lw_404_sb",  32'h404,  32'h0,        0, 0, 3, 0, 32'hDEAABE11);

    repeat (3) @(posedge Clk);
    #1;
    check32("reset_dout", MEM_DataOut, 32'h0);
    check32("reset_busy", {31'b0, Busy}, 32'h0);
    check32("reset_done", {31'b0, Done}, 32'h0);
    check32("reset_err",  {31'b0, Err},  32'h0);
    @(negedge Clk) Reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].bop, lat, e, q);
      check32({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].lat));
      check32({vecs[i].name, "_err"},  {31'b0, e}, {31'b0, vecs[i].err});
      check32({vecs[i].name, "_dout"}, q, vecs[i].dout);
    end

    // Start re-asserted during ACCESS of an sb must be ignored
    do_req(32'h40C, 32'h11223344, 1, 0, lat, e, q);
    @(negedge Clk);
    MEM_Addr = 32'h40C; MEM_DataIn = 32'h00000055; MEM_WrEn = 1; Byte_op = 1; Start = 1;
    @(posedge Clk);
    @(negedge Clk);
    MEM_DataIn = 32'hFFFFFFFF; Byte_op = 0;
    @(posedge Clk);
    @(negedge Clk);
    Start = 0;
    dones = Done ? 1 : 0;
    repeat (8) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    check32("busy_start_dones", 32'(dones), 32'd1);
    do_req(32'h40C, 32'h0, 0, 0, lat, e, q);
    check32("busy_start_mem", q, 32'h11223355);

    // Reset during MERGE of an sb aborts the write
    do_req(32'h408, 32'hCAFEF00D, 1, 0, lat, e, q);
    @(negedge Clk);
    MEM_Addr = 32'h408; MEM_DataIn = 32'h00000077; MEM_WrEn = 1; Byte_op = 1; Start = 1;
    @(posedge Clk);
    #1 Start = 0;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check32("midreset_busy", {31'b0, Busy}, 32'h0);
    check32("midreset_done", {31'b0, Done}, 32'h0);
    check32("midreset_err",  {31'b0, Err},  32'h0);
    check32("midreset_dout", MEM_DataOut, 32'h0);
    @(negedge Clk) Reset_n = 1'b1;
    do_req(32'h408, 32'h0, 0, 0, lat, e, q);
    check32("midreset_lw_408", q, 32'hCAFEF00D);

    // Randomized phase over a preloaded 16-word window
    m_dout = 32'hCAFEF00D;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model(BASE + 32'(4 * i), d, 1, 0, exp_lat, exp_e);
      do_req(BASE + 32'(4 * i), d, 1, 0, lat, e, q);
      check32("pre_lat", 32'(lat), 32'(exp_lat));
    end
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: a = BASE - 32'(4 * $urandom_range(1, 8));
        1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      d   = $urandom;
      wr  = 1'($urandom_range(0, 1));
      bop = 1'($urandom_range(0, 1));
      model(a, d, wr, bop, exp_lat, exp_e);
      do_req(a, d, wr, bop, lat, e, q);
      check32("rnd_lat",  32'(lat), 32'(exp_lat));
      check32("rnd_err",  {31'b0, e}, {31'b0, exp_e});
      check32("rnd_dout", q, m_dout);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
